rgb_edit_sequencer: RTL and testbench
=====================================

Name: rgb_edit_sequencer

Overview:
- Sequences the 8-bit RGB value driven to the VGA colour path from five push-buttons (up, down, left, right, centre).
- Debounces the buttons, then runs an edit state machine:
  - L/R select a channel.
  - U/D step the selected channel with saturation.
  - C commits the edited colour.
- The commit is applied only on a frame boundary, so the displayed colour never changes mid-frame.
- Sits between the board buttons and the colour controller; its rgb_out feeds the colour stage.

Parameters:
- DEBOUNCE_CYCLES, 500000, clock cycles a synchronised button level must stay stable before acceptance (10 ms at 50 MHz).
- RESET_RGB, 8'h00, value of rgb_out and rgb_edit after reset.
- REPEAT_CYCLES, 25000000, hold time before/between auto-repeat steps; used only with AUTO_REPEAT_EN.

Ports:
- clk  input  1  system clock; one clock domain.
- rst_n  input  1  synchronous, active-low reset.
- B_U, B_D, B_L, B_R, B_C  input  1 each  raw asynchronous push-buttons, active-high.
- frame_start  input  1  one-cycle pulse at start of vertical blanking, from the sync generator.
- rgb_out  output  8  committed colour: R=[7:5], G=[4:2], B=[1:0].
- rgb_edit  output  8  colour currently being edited.
- sel  output  2  selected channel: 0=R, 1=G, 2=B; 3 is never driven.
- commit_pending  output  1  high while waiting for frame_start to commit.

Behaviour:
- Reset (rst_n low at a clk edge):
  - rgb_out = rgb_edit = RESET_RGB, sel = 0, commit_pending = 0, FSM = IDLE.
  - All debounce counters and synchroniser flops clear to 0 (released level).
- Button input path:
  - Each button passes through a 2-flop synchroniser, then a debounce counter.
  - The debounced level changes after DEBOUNCE_CYCLES consecutive cycles of a stable synchronised level.
  - Press pulse: 1 cycle on the debounced 0->1 edge.
  - Press-to-pulse latency = 2 + DEBOUNCE_CYCLES cycles.
  - A release shorter than DEBOUNCE_CYCLES is ignored.
- Action arbitration:
  - At most one action per cycle; priority C > U > D > R > L.
  - Lower-priority pulses in the same cycle are dropped, not queued.
- FSM states: IDLE, EDIT, COMMIT_WAIT.
  - IDLE:
    - U/D/L/R pulse -> apply the action, go to EDIT.
    - C pulse -> ignored.
  - EDIT:
    - U/D/L/R pulse -> apply the action, stay in EDIT.
    - C pulse -> COMMIT_WAIT, commit_pending = 1.
  - COMMIT_WAIT:
    - All button pulses are ignored.
    - On frame_start: rgb_out <= rgb_edit, commit_pending = 0, go to IDLE.
    - A frame_start in the same cycle as the C pulse that entered COMMIT_WAIT does not commit; the next frame_start does.
- Actions:
  - U: selected field +1, saturating (R/G max 7, B max 3).
  - D: selected field -1, saturating at 0.
  - R: sel 0->1->2->0.
  - L: sel 0->2->1->0.
  - All actions update rgb_edit/sel on the clock edge after the pulse cycle.
- rgb_edit and rgb_out are registered; nothing combinational from the buttons reaches the outputs.
- Reset mid-operation: a pending commit is discarded; rgb_out returns to RESET_RGB.

Optional Feature:
- Macro: RGB_EDIT_AUTO_REPEAT_EN.
- When defined:
  - While debounced U or D stays high in EDIT, an extra step pulse is generated after REPEAT_CYCLES, then every REPEAT_CYCLES.
  - The repeat counter is shared and cleared on any press, release or state change.
  - Auto-repeat is never applied to L, R or C.
- When undefined: exactly one step per press; no repeat counter is synthesised.

Decomposition:
- Shared package rgb_pkg:
  - FSM state typedef (IDLE/EDIT/COMMIT_WAIT).
  - Channel select constants SEL_R/SEL_G/SEL_B.
  - Field bit ranges and max constants R_MAX=7, G_MAX=7, B_MAX=3.
- Sub-module btn_debounce (parameter DEBOUNCE_CYCLES):
  - Contains the synchroniser and counter.
  - Outputs a debounced level and a press pulse.
  - Instantiated five times.

Test Plan (bench uses DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8):
- Reset: hold rst_n=0 for 3 cycles -> rgb_out=rgb_edit=8'h00, sel=0, commit_pending=0. Assert B_U during reset -> no change.
- Debounce: B_U high for 3 cycles, then low -> rgb_edit unchanged. B_U high for 10 cycles -> rgb_edit=8'h20, exactly one step.
- Saturation: sel=B, press U four times -> rgb_edit[1:0]=3. Press D five times -> rgb_edit[1:0]=0.
- Channel wrap: press L from sel=0 -> sel=2. Press R three times -> sel=2.
- Commit: edit to 8'hE4, press C -> commit_pending=1, rgb_out still 8'h00. Pulse frame_start -> rgb_out=8'hE4 on the next edge, FSM back to IDLE.
- Simultaneous events: debounced U and C pulses in the same EDIT cycle -> only the commit is taken, rgb_edit unchanged. Button presses during COMMIT_WAIT are ignored. rst_n low during COMMIT_WAIT -> rgb_out=8'h00, no commit.

Source files
------------

// File: rtl/rgb_pkg.sv
// rgb_pkg: definitions shared by the RGB edit sequencer and its sub-blocks.
//   - Edit FSM state type (IDLE / EDIT / COMMIT_WAIT) and arbitrated action type.
//   - Channel select codes SEL_R / SEL_G / SEL_B.
//   - Button bit indices into the packed button vectors.
//   - Colour field bit ranges and per-field maxima (R=[7:5], G=[4:2], B=[1:0]).
//   - Helpers: saturating step of the selected field, and channel rotation.
package rgb_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    EDIT        = 2'd1,
    COMMIT_WAIT = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    ACT_NONE = 3'd0,
    ACT_C    = 3'd1,
    ACT_U    = 3'd2,
    ACT_D    = 3'd3,
    ACT_R    = 3'd4,
    ACT_L    = 3'd5
  } action_e;

  localparam logic [1:0] SEL_R = 2'd0;
  localparam logic [1:0] SEL_G = 2'd1;
  localparam logic [1:0] SEL_B = 2'd2;

  localparam int NUM_BTNS = 5;
  localparam int BTN_L    = 0;
  localparam int BTN_R    = 1;
  localparam int BTN_D    = 2;
  localparam int BTN_U    = 3;
  localparam int BTN_C    = 4;

  localparam int R_HI = 7;
  localparam int R_LO = 5;
  localparam int G_HI = 4;
  localparam int G_LO = 2;
  localparam int B_HI = 1;
  localparam int B_LO = 0;

  localparam logic [2:0] R_MAX = 3'd7;
  localparam logic [2:0] G_MAX = 3'd7;
  localparam logic [1:0] B_MAX = 2'd3;

  // Step the selected field by one in the requested direction, holding at
  // 0 and at the field maximum instead of wrapping.
  function automatic logic [7:0] stepChannel(input logic [7:0] rgb,
                                             input logic [1:0] sel,
                                             input logic       up);
    logic [7:0] res;
    res = rgb;
    case (sel)
      SEL_R: begin
        if (up) begin
          if (rgb[R_HI:R_LO] != R_MAX) res[R_HI:R_LO] = rgb[R_HI:R_LO] + 3'd1;
        end else if (rgb[R_HI:R_LO] != 3'd0) begin
          res[R_HI:R_LO] = rgb[R_HI:R_LO] - 3'd1;
        end
      end
      SEL_G: begin
        if (up) begin
          if (rgb[G_HI:G_LO] != G_MAX) res[G_HI:G_LO] = rgb[G_HI:G_LO] + 3'd1;
        end else if (rgb[G_HI:G_LO] != 3'd0) begin
          res[G_HI:G_LO] = rgb[G_HI:G_LO] - 3'd1;
        end
      end
      SEL_B: begin
        if (up) begin
          if (rgb[B_HI:B_LO] != B_MAX) res[B_HI:B_LO] = rgb[B_HI:B_LO] + 2'd1;
        end else if (rgb[B_HI:B_LO] != 2'd0) begin
          res[B_HI:B_LO] = rgb[B_HI:B_LO] - 2'd1;
        end
      end
      default: res = rgb;
    endcase
    return res;
  endfunction

  // Rotate the channel select: right goes R->G->B->R, left goes R->B->G->R.
  function automatic logic [1:0] nextSel(input logic [1:0] sel, input logic right);
    logic [1:0] res;
    case (sel)
      SEL_R:   res = right ? SEL_G : SEL_B;
      SEL_G:   res = right ? SEL_B : SEL_R;
      SEL_B:   res = right ? SEL_R : SEL_G;
      default: res = SEL_R;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser plus stability counter for one push-button.
//   clk      in   system clock
//   rst_n    in   synchronous active-low reset (clears to released level)
//   btn_i    in   raw asynchronous button, active-high
//   level_o  out  debounced button level
//   press_o  out  one-cycle pulse on the debounced 0->1 transition
// The debounced level follows the synchronised level only after it has
// differed from it for DEBOUNCE_CYCLES consecutive cycles.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any cycle where the synchronised level agrees with the accepted level
  // restarts the count, so a short bounce or glitch never accumulates.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/rgb_edit_sequencer.sv
// rgb_edit_sequencer: button-driven editor for the 8-bit VGA colour.
//   clk             in   system clock
//   rst_n           in   synchronous active-low reset
//   B_U/B_D/B_L/B_R/B_C in raw push-buttons (up/down/left/right/centre)
//   frame_start     in   one-cycle pulse at start of vertical blanking
//   rgb_out         out  committed colour R=[7:5] G=[4:2] B=[1:0]
//   rgb_edit        out  colour currently being edited
//   sel             out  selected channel (0=R, 1=G, 2=B)
//   commit_pending  out  high while a commit waits for frame_start
// L/R rotate the channel, U/D step it with saturation, C requests a commit
// that lands on the next frame_start so the picture never changes mid-frame.
// Optional macro RGB_EDIT_AUTO_REPEAT_EN: holding U or D in EDIT produces an
// extra step every REPEAT_CYCLES.
module rgb_edit_sequencer
  import rgb_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES = 500000,
  parameter logic [7:0] RESET_RGB       = 8'h00,
  parameter int         REPEAT_CYCLES   = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       B_U,
  input  logic       B_D,
  input  logic       B_L,
  input  logic       B_R,
  input  logic       B_C,
  input  logic       frame_start,
  output logic [7:0] rgb_out,
  output logic [7:0] rgb_edit,
  output logic [1:0] sel,
  output logic       commit_pending
);

  logic [NUM_BTNS-1:0] btnRaw, btnLevel, btnPress;
  logic                stepUp, stepDn;
  action_e             act;

  state_e     state_q, state_d;
  logic [7:0] rgbEdit_q, rgbEdit_d;
  logic [7:0] rgbOut_q, rgbOut_d;
  logic [1:0] sel_q, sel_d;

  assign btnRaw = {B_C, B_U, B_D, B_R, B_L};

  for (genvar i = 0; i < NUM_BTNS; i++) begin : gBtn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) uDebounce (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_i  (btnRaw[i]),
      .level_o(btnLevel[i]),
      .press_o(btnPress[i])
    );
  end

`ifdef RGB_EDIT_AUTO_REPEAT_EN
  localparam int RPT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

  logic [RPT_W-1:0] rptCnt_q, rptCnt_d;
  logic [1:0]       udLevel_q;
  logic             rptFire;
  logic             unusedLevels;

  // One counter serves both U and D; any press, any change of the held U/D
  // levels, or leaving EDIT restarts the hold interval from zero.
  always_comb begin
    rptCnt_d = rptCnt_q;
    rptFire  = 1'b0;
    if ((|btnPress) || (udLevel_q != {btnLevel[BTN_U], btnLevel[BTN_D]}) ||
        (state_q != EDIT) || !(btnLevel[BTN_U] || btnLevel[BTN_D])) begin
      rptCnt_d = '0;
    end else if (rptCnt_q == RPT_LAST) begin
      rptFire  = 1'b1;
      rptCnt_d = '0;
    end else begin
      rptCnt_d = rptCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rptCnt_q  <= '0;
      udLevel_q <= 2'b00;
    end else begin
      rptCnt_q  <= rptCnt_d;
      udLevel_q <= {btnLevel[BTN_U], btnLevel[BTN_D]};
    end
  end

  // U wins when both are held, matching the press priority.
  assign stepUp       = btnPress[BTN_U] | (rptFire & btnLevel[BTN_U]);
  assign stepDn       = btnPress[BTN_D] | (rptFire & ~btnLevel[BTN_U] & btnLevel[BTN_D]);
  assign unusedLevels = ^{btnLevel[BTN_C], btnLevel[BTN_R], btnLevel[BTN_L]};
`else
  logic unusedCfg;

  assign stepUp    = btnPress[BTN_U];
  assign stepDn    = btnPress[BTN_D];
  assign unusedCfg = (^btnLevel) ^ (REPEAT_CYCLES == 0);
`endif

  // Only one action per cycle; lower-priority pulses are simply dropped.
  always_comb begin
    act = ACT_NONE;
    if (btnPress[BTN_C])      act = ACT_C;
    else if (stepUp)          act = ACT_U;
    else if (stepDn)          act = ACT_D;
    else if (btnPress[BTN_R]) act = ACT_R;
    else if (btnPress[BTN_L]) act = ACT_L;
  end

  // Edit FSM. A frame_start arriving in the same cycle as the C pulse is
  // seen while still in EDIT, so it cannot commit; the next one does.
  always_comb begin
    state_d   = state_q;
    rgbEdit_d = rgbEdit_q;
    rgbOut_d  = rgbOut_q;
    sel_d     = sel_q;
    case (state_q)
      IDLE, EDIT: begin
        case (act)
          ACT_C: begin
            if (state_q == EDIT) state_d = COMMIT_WAIT;
          end
          ACT_U: begin
            rgbEdit_d = stepChannel(rgbEdit_q, sel_q, 1'b1);
            state_d   = EDIT;
          end
          ACT_D: begin
            rgbEdit_d = stepChannel(rgbEdit_q, sel_q, 1'b0);
            state_d   = EDIT;
          end
          ACT_R: begin
            sel_d   = nextSel(sel_q, 1'b1);
            state_d = EDIT;
          end
          ACT_L: begin
            sel_d   = nextSel(sel_q, 1'b0);
            state_d = EDIT;
          end
          default: ;
        endcase
      end
      COMMIT_WAIT: begin
        if (frame_start) begin
          rgbOut_d = rgbEdit_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rgbEdit_q <= RESET_RGB;
      rgbOut_q  <= RESET_RGB;
      sel_q     <= SEL_R;
    end else begin
      state_q   <= state_d;
      rgbEdit_q <= rgbEdit_d;
      rgbOut_q  <= rgbOut_d;
      sel_q     <= sel_d;
    end
  end

  assign rgb_out        = rgbOut_q;
  assign rgb_edit       = rgbEdit_q;
  assign sel            = sel_q;
  assign commit_pending = (state_q == COMMIT_WAIT);

endmodule

// File: tb/tb_rgb_edit_sequencer.sv
// tb_rgb_edit_sequencer: testbench for rgb_edit_sequencer with short debounce
// and repeat intervals. Directed corner sequences, a vector table, then random
// button/frame traffic compared against a channel-level colour model.
module tb_rgb_edit_sequencer;

  localparam int DEB  = 4;
  localparam int RPT  = 8;
  localparam int HOLD = 12;
  localparam int GAP  = 12;

  localparam logic [4:0] M_C = 5'b10000;
  localparam logic [4:0] M_U = 5'b01000;
  localparam logic [4:0] M_D = 5'b00100;
  localparam logic [4:0] M_R = 5'b00010;
  localparam logic [4:0] M_L = 5'b00001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       B_U = 1'b0, B_D = 1'b0, B_L = 1'b0, B_R = 1'b0, B_C = 1'b0;
  logic       frame_start = 1'b0;
  logic [7:0] rgb_out, rgb_edit;
  logic [1:0] sel;
  logic       commit_pending;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: 0=idle, 1=edit, 2=waiting for frame
  int mState, mR, mG, mB, mSel, mOut;

  typedef struct {
    logic [4:0] btns;
    logic       frame;
    logic [7:0] expEdit;
    logic [1:0] expSel;
    logic       expPend;
    logic [7:0] expOut;
  } vec_t;

  vec_t vecs[13];

  always #5 clk = ~clk;

  rgb_edit_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .RESET_RGB      (8'h00),
    .REPEAT_CYCLES  (RPT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .B_U           (B_U),
    .B_D           (B_D),
    .B_L           (B_L),
    .B_R           (B_R),
    .B_C           (B_C),
    .frame_start   (frame_start),
    .rgb_out       (rgb_out),
    .rgb_edit      (rgb_edit),
    .sel           (sel),
    .commit_pending(commit_pending)
  );

  task automatic setButtons(input logic [4:0] m);
    {B_C, B_U, B_D, B_R, B_L} = m;
  endtask

  // Press the masked buttons long enough to debounce, then release fully.
  // Optionally follow with a single-cycle frame_start pulse.
  task automatic applyStimulus(input logic [4:0] btns, input logic frame);
    if (btns != 5'b0) begin
      setButtons(btns);
      repeat (HOLD) @(negedge clk);
      setButtons(5'b0);
      repeat (GAP) @(negedge clk);
    end
    if (frame) begin
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string name, input logic [7:0] eEdit,
                          input logic [1:0] eSel, input logic ePend,
                          input logic [7:0] eOut);
    checkOutput({name, ".rgb_edit"}, rgb_edit, eEdit);
    checkOutput({name, ".sel"}, {6'b0, sel}, {6'b0, eSel});
    checkOutput({name, ".pending"}, {7'b0, commit_pending}, {7'b0, ePend});
    checkOutput({name, ".rgb_out"}, rgb_out, eOut);
  endtask

  function automatic int modelRgb();
    return mR * 32 + mG * 4 + mB;
  endfunction

  function automatic int clampInt(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic modelReset();
    mState = 0; mR = 0; mG = 0; mB = 0; mSel = 0; mOut = 0;
  endtask

  // Highest-priority button wins: C, U, D, R, L.
  task automatic modelButtons(input logic [4:0] m);
    int delta;
    if (m == 5'b0 || mState == 2) return;
    if (m[4]) begin
      if (mState == 1) mState = 2;
      return;
    end
    if (m[3] || m[2]) begin
      delta = m[3] ? 1 : -1;
      if (mSel == 0)      mR = clampInt(mR + delta, 7);
      else if (mSel == 1) mG = clampInt(mG + delta, 7);
      else                mB = clampInt(mB + delta, 3);
    end else if (m[1]) begin
      mSel = (mSel + 1) % 3;
    end else begin
      mSel = (mSel + 2) % 3;
    end
    mState = 1;
  endtask

  task automatic modelFrame();
    if (mState == 2) begin
      mOut = modelRgb();
      mState = 0;
    end
  endtask

  initial begin
    logic [4:0] m;
    int         op;
    logic [4:0] singles[5];

    vecs[0]  = '{M_U, 1'b0, 8'h20, 2'd0, 1'b0, 8'h00};
    vecs[1]  = '{M_U, 1'b0, 8'h40, 2'd0, 1'b0, 8'h00};
    vecs[2]  = '{M_R, 1'b0, 8'h40, 2'd1, 1'b0, 8'h00};
    vecs[3]  = '{M_U, 1'b0, 8'h44, 2'd1, 1'b0, 8'h00};
    vecs[4]  = '{M_L, 1'b0, 8'h44, 2'd0, 1'b0, 8'h00};
    vecs[5]  = '{M_D, 1'b0, 8'h24, 2'd0, 1'b0, 8'h00};
    vecs[6]  = '{M_L, 1'b0, 8'h24, 2'd2, 1'b0, 8'h00};
    vecs[7]  = '{M_U, 1'b0, 8'h25, 2'd2, 1'b0, 8'h00};
    vecs[8]  = '{M_C, 1'b0, 8'h25, 2'd2, 1'b1, 8'h00};
    vecs[9]  = '{M_U, 1'b0, 8'h25, 2'd2, 1'b1, 8'h00};
    vecs[10] = '{5'b0, 1'b1, 8'h25, 2'd2, 1'b0, 8'h25};
    vecs[11] = '{M_C, 1'b0, 8'h25, 2'd2, 1'b0, 8'h25};
    vecs[12] = '{M_U, 1'b0, 8'h26, 2'd2, 1'b0, 8'h25};

    singles[0] = M_U; singles[1] = M_D; singles[2] = M_L;
    singles[3] = M_R; singles[4] = M_C;

    // Reset with U held: nothing may leak through once reset releases.
    @(negedge clk);
    rst_n = 1'b0;
    B_U = 1'b1;
    repeat (3) @(negedge clk);
    B_U = 1'b0;
    rst_n = 1'b1;
    repeat (HOLD) @(negedge clk);
    checkAll("reset", 8'h00, 2'd0, 1'b0, 8'h00);

    // Debounce: a 3-cycle glitch is ignored, a long press steps exactly once.
    B_U = 1'b1;
    repeat (3) @(negedge clk);
    B_U = 1'b0;
    repeat (GAP) @(negedge clk);
    checkOutput("glitch.rgb_edit", rgb_edit, 8'h00);
    B_U = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("press.rgb_edit", rgb_edit, 8'h20);
    repeat (20) @(negedge clk);
    checkOutput("held.rgb_edit", rgb_edit, 8'h20);
    B_U = 1'b0;
    repeat (GAP) @(negedge clk);

    // Channel wrap left, then saturation on the 2-bit blue field.
    applyStimulus(M_L, 1'b0);
    checkOutput("wrapL.sel", {6'b0, sel}, 8'd2);
    repeat (4) applyStimulus(M_U, 1'b0);
    checkOutput("satB.up", rgb_edit, 8'h23);
    repeat (5) applyStimulus(M_D, 1'b0);
    checkOutput("satB.down", rgb_edit, 8'h20);
    repeat (3) applyStimulus(M_R, 1'b0);
    checkOutput("wrapR.sel", {6'b0, sel}, 8'd2);

    // Build E4 (R=7 saturated from 1 by six steps, G=1), then commit.
    applyStimulus(M_R, 1'b0);
    repeat (6) applyStimulus(M_U, 1'b0);
    applyStimulus(M_R, 1'b0);
    applyStimulus(M_U, 1'b0);
    checkOutput("build.rgb_edit", rgb_edit, 8'hE4);
    applyStimulus(M_C, 1'b0);
    checkAll("commitReq", 8'hE4, 2'd1, 1'b1, 8'h00);
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("commit.rgb_out", rgb_out, 8'hE4);
    checkOutput("commit.pending", {7'b0, commit_pending}, 8'd0);
    @(negedge clk);
    frame_start = 1'b0;
    applyStimulus(M_C, 1'b0);
    checkOutput("idleC.pending", {7'b0, commit_pending}, 8'd0);

    // Simultaneous U+C in EDIT: only the commit is taken.
    applyStimulus(M_U, 1'b0);
    checkOutput("g2.rgb_edit", rgb_edit, 8'hE8);
    applyStimulus(M_C | M_U, 1'b0);
    checkAll("UC", 8'hE8, 2'd1, 1'b1, 8'hE4);
    applyStimulus(M_D, 1'b0);
    checkAll("cwIgnore", 8'hE8, 2'd1, 1'b1, 8'hE4);
    doReset();
    checkAll("cwReset", 8'h00, 2'd0, 1'b0, 8'h00);
    applyStimulus(5'b0, 1'b1);
    checkOutput("noCommit.rgb_out", rgb_out, 8'h00);

    // Vector table from a fresh reset.
    doReset();
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].btns, vecs[i].frame);
      checkAll($sformatf("tbl%0d", i), vecs[i].expEdit, vecs[i].expSel,
               vecs[i].expPend, vecs[i].expOut);
    end

    // Random traffic against the channel-level model.
    doReset();
    modelReset();
    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 9);
      if (op <= 5) begin
        m = singles[(op == 5) ? 4 : op];
        applyStimulus(m, 1'b0);
        modelButtons(m);
      end else if (op == 6) begin
        applyStimulus(5'b0, 1'b1);
        modelFrame();
      end else begin
        m = 5'($urandom_range(1, 31));
        applyStimulus(m, 1'b0);
        modelButtons(m);
      end
      checkAll($sformatf("rnd%0d", i), 8'(modelRgb()), 2'(mSel),
               (mState == 2), 8'(mOut));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
